fb_pixel_writer: RTL and testbench

- Upstream neighbour of the VGA display stage.
- Accepts an RGB565 pixel stream with a start-of-frame marker and buffers it in a small internal FIFO.
- Writes each pixel into the SDRAM framebuffer through single Wishbone classic write cycles, at the same pixel-index addresses the display stage reads.
- Replaces the fixed test-pattern loader as the source of framebuffer content (camera or generator feed).

---
 rtl/fb_pixel_writer.sv | 207 ++++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers an RGB565 pixel stream in a small FIFO and writes
// each pixel into the framebuffer with single Wishbone classic write cycles.
// Pixel index idx maps to byte address BASE_ADDR + 2*idx, matching the
// addressing used by the display stage that reads the framebuffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no bus cycle open; pops the FIFO head when data and enable
// S_WRITE | write cycle open; adr/dat held until ack, may chain next pop
module fb_pixel_writer #(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          FIFO_AW   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  output logic [31:0] wb_adr,
  output logic [15:0] wb_dat_ms,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [1:0]  wb_sel,
  input  logic        wb_ack,
  output logic        frame_done,
  output logic        sof_err
);

  localparam int NPIX  = HDISP * VDISP;
  localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [IW-1:0]      LAST_IDX = IW'(NPIX - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [16:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_run;

  logic [IW-1:0] r_next_idx;
  logic [IW-1:0] r_cur_idx;
  logic          r_sof_err;
  logic          r_frame_done;

  logic [31:0] r_adr;
  logic [15:0] r_dat;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [1:0]  r_sel;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_close;
  logic          w_ack_ok;
  logic [16:0]   w_head;
  logic          w_head_sof;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_wr_idx_inc;

  // r_run keeps pix_ready low through reset and releases it one cycle later,
  // so ready is a pure function of registered state and enable.
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign pix_ready  = r_run && enable && !w_full;
  assign w_push     = pix_valid && pix_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_head_sof = w_head[16];
  assign w_ack_ok   = (r_state == S_WRITE) && wb_ack;

  // A SOF entry always restarts the frame at index 0.
  assign w_wr_idx     = w_head_sof ? '0 : r_next_idx;
  assign w_wr_idx_inc = (w_wr_idx == LAST_IDX) ? '0 : w_wr_idx + 1'b1;

  // FIFO storage, left unreset so it can map onto distributed RAM.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {pix_sof, pix_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, pop and cycle-close decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && enable) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wb_ack) begin
          if (!w_empty && enable) begin
            w_pop = 1'b1;
          end else begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write index tracking, frame_done pulse and sticky SOF error.
  // r_next_idx advances when a pixel is popped; since pops and acks occur in
  // the same order this equals the post-ack index seen by the next pixel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_next_idx   <= '0;
      r_cur_idx    <= '0;
      r_sof_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_ack_ok && (r_cur_idx == LAST_IDX);
      if (w_pop) begin
        r_cur_idx  <= w_wr_idx;
        r_next_idx <= w_wr_idx_inc;
        if (w_head_sof && (r_next_idx != '0)) begin
          r_sof_err <= 1'b1;
        end
      end
    end
  end

  // Registered Wishbone master outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_adr <= '0;
      r_dat <= '0;
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we  <= 1'b0;
      r_sel <= 2'b00;
    end else if (w_pop) begin
      r_adr <= BASE_ADDR + (32'(w_wr_idx) << 1);
      r_dat <= w_head[15:0];
      r_cyc <= 1'b1;
      r_stb <= 1'b1;
      r_we  <= 1'b1;
      r_sel <= 2'b11;
    end else if (w_close) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we  <= 1'b0;
      r_sel <= 2'b00;
    end
  end

  assign wb_adr     = r_adr;
  assign wb_dat_ms  = r_dat;
  assign wb_cyc     = r_cyc;
  assign wb_stb     = r_stb;
  assign wb_we      = r_we;
  assign wb_sel     = r_sel;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer with a tiny 4x2 frame.
module tb_fb_pixel_writer;

  localparam int          HD   = 4;
  localparam int          VD   = 2;
  localparam int          NPIX = HD * VD;
  localparam logic [31:0] BASE = 32'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic [31:0] wb_adr;
  logic [15:0] wb_dat_ms;
  logic        wb_cyc, wb_stb, wb_we;
  logic [1:0]  wb_sel;
  logic        wb_ack;
  logic        frame_done, sof_err;

  logic ack_en    = 1'b1;
  logic zero_wait = 1'b1;
  int   wait_cnt  = 0;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int   m_idx = 0;
  logic m_sof_err = 1'b0;
  int   m_fd = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];

  // monitor counters
  int fd_cnt = 0, fd_bad = 0, stab_bad = 0, bus_bad = 0, full_cnt = 0;
  logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
  logic [31:0] prev_adr = '0;
  logic [15:0] prev_dat = '0;

  fb_pixel_writer #(.HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_AW(4)) dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_ack(wb_ack),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 CLK = ~CLK;

  // slave: zero-wait acks immediately, otherwise 3 wait cycles per write
  assign wb_ack = ack_en && wb_stb && wb_cyc && (zero_wait || wait_cnt >= 3);

  always @(posedge CLK) wait_cnt <= (wb_stb && !wb_ack) ? wait_cnt + 1 : 0;

  // bus monitor: records completed writes and protocol anomalies
  always @(negedge CLK) begin
    if (!RST) begin
      if (wb_stb && wb_cyc && wb_ack) obs_q.push_back({wb_adr, wb_dat_ms});
      if (wb_stb && (!wb_cyc || !wb_we || wb_sel != 2'b11)) bus_bad <= bus_bad + 1;
      if (prev_stb && !prev_ack && !prev_rst &&
          (!wb_stb || wb_adr != prev_adr || wb_dat_ms != prev_dat)) stab_bad <= stab_bad + 1;
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        if (!prev_last) fd_bad <= fd_bad + 1;
      end
      if (enable && pix_valid && !pix_ready) full_cnt <= full_cnt + 1;
    end
    prev_stb  <= wb_stb;
    prev_ack  <= wb_ack;
    prev_rst  <= RST;
    prev_adr  <= wb_adr;
    prev_dat  <= wb_dat_ms;
    prev_last <= wb_stb && wb_cyc && wb_ack && (wb_adr == BASE + 32'(2 * (NPIX - 1)));
  end

  // reference model: the expected write of each accepted pixel, in order
  function automatic void model_push(input logic [15:0] d, input logic s);
    if (s) begin
      if (m_idx != 0) m_sof_err = 1'b1;
      m_idx = 0;
    end
    exp_q.push_back({BASE + 32'(2 * m_idx), d});
    if (m_idx == NPIX - 1) m_fd++;
    m_idx = (m_idx + 1) % NPIX;
  endfunction

  task automatic send_pix(input logic [15:0] d, input logic s, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge CLK); #1;
    end
    pix_valid = 1'b1; pix_data = d; pix_sof = s;
    while (!pix_ready && t < 500) begin
      @(posedge CLK); #1; t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL accept_timeout got ready=%0b after %0d cycles exp ready=1", pix_ready, t);
    end else begin
      model_push(d, s);
    end
    @(posedge CLK); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 2000) begin
      @(posedge CLK); t++;
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int hi = 0;
    RST = 1'b1; enable = 1'b1; pix_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({pix_ready, wb_cyc, wb_stb, wb_we, wb_sel, frame_done, sof_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000000",
               {pix_ready, wb_cyc, wb_stb, wb_we, wb_sel, frame_done, sof_err});
    end
    checks++;
    if ({wb_adr, wb_dat_ms} !== 48'h0) begin
      errors++;
      $display("FAIL reset_bus got adr=%h dat=%h exp 0/0", wb_adr, wb_dat_ms);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", pix_ready);
    end
    enable = 1'b0; #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL disabled_ready got %b exp 0", pix_ready);
    end
    enable = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (wb_stb !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL idle_stb got %0d cycles high exp 0", hi);
    end
  endtask

  task automatic test_single();
    int fd0 = fd_cnt, fb0 = fd_bad, sb0 = stab_bad, bb0 = bus_bad, m0 = m_fd;
    zero_wait = 1'b1; ack_en = 1'b1;
    exp_q.delete(); obs_q.delete();
    pix_valid = 1'b1; pix_data = 16'h0001; pix_sof = 1'b1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b exp 1", pix_ready);
    end
    model_push(16'h0001, 1'b1);
    @(posedge CLK); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
    checks++;
    if (wb_stb !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1 got stb=%b exp 0", wb_stb);
    end
    @(posedge CLK); #1;
    checks++;
    if ({wb_stb, wb_adr, wb_dat_ms} !== {1'b1, 32'h0, 16'h0001}) begin
      errors++;
      $display("FAIL latency_n2 got stb=%b adr=%h dat=%h exp 1/0/0001", wb_stb, wb_adr, wb_dat_ms);
    end
    for (int i = 2; i <= 8; i++) send_pix(16'(i), 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - fd0 != m_fd - m0 || fd_bad != fb0) begin
      errors++;
      $display("FAIL single_frame_done got %0d (misplaced %0d) exp %0d", fd_cnt - fd0, fd_bad - fb0, m_fd - m0);
    end
    checks++;
    if (stab_bad != sb0 || bus_bad != bb0 || sof_err !== m_sof_err) begin
      errors++;
      $display("FAIL single_proto got stab=%0d bus=%0d sof_err=%b exp 0/0/%b",
               stab_bad - sb0, bus_bad - bb0, sof_err, m_sof_err);
    end
  endtask

  task automatic test_waitstate();
    int fd0 = fd_cnt, fb0 = fd_bad, sb0 = stab_bad, bb0 = bus_bad, fc0 = full_cnt, m0 = m_fd;
    zero_wait = 1'b0; ack_en = 1'b1;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 32; i++) send_pix(16'($urandom), (i % 8) == 0, 1'b0);
    wait_drain();
    checks++;
    if (full_cnt == fc0) begin
      errors++;
      $display("FAIL wait_backpressure got 0 stalled cycles exp >0");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wait_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wait_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - fd0 != m_fd - m0 || fd_bad != fb0) begin
      errors++;
      $display("FAIL wait_frame_done got %0d (misplaced %0d) exp %0d", fd_cnt - fd0, fd_bad - fb0, m_fd - m0);
    end
    checks++;
    if (stab_bad != sb0 || bus_bad != bb0 || sof_err !== m_sof_err) begin
      errors++;
      $display("FAIL wait_proto got stab=%0d bus=%0d sof_err=%b exp 0/0/%b",
               stab_bad - sb0, bus_bad - bb0, sof_err, m_sof_err);
    end
  endtask

  task automatic test_wrap();
    int fd0 = fd_cnt, fb0 = fd_bad, sb0 = stab_bad, m0 = m_fd;
    zero_wait = 1'b1; ack_en = 1'b1;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 16; i++) send_pix(16'($urandom), (i % 8) == 0, 1'b1);
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - fd0 != m_fd - m0 || fd_bad != fb0) begin
      errors++;
      $display("FAIL wrap_frame_done got %0d (misplaced %0d) exp %0d", fd_cnt - fd0, fd_bad - fb0, m_fd - m0);
    end
    checks++;
    if (stab_bad != sb0 || sof_err !== m_sof_err) begin
      errors++;
      $display("FAIL wrap_proto got stab=%0d sof_err=%b exp 0/%b", stab_bad - sb0, sof_err, m_sof_err);
    end
  endtask

  task automatic test_short();
    int fd0 = fd_cnt, m0 = m_fd;
    zero_wait = 1'b1; ack_en = 1'b1;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) send_pix(16'($urandom), i == 0, 1'b1);
    for (int i = 0; i < 8; i++) send_pix(16'($urandom), i == 0, 1'b1);
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL short_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sof_err !== m_sof_err) begin
      errors++;
      $display("FAIL short_sof_err got %b exp %b", sof_err, m_sof_err);
    end
    checks++;
    if (fd_cnt - fd0 != m_fd - m0) begin
      errors++;
      $display("FAIL short_frame_done got %0d exp %0d", fd_cnt - fd0, m_fd - m0);
    end
  endtask

  task automatic test_mid_reset();
    int t = 0;
    int hi = 0;
    zero_wait = 1'b0; ack_en = 1'b0;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 3; i++) send_pix(16'($urandom), i == 0, 1'b0);
    while (wb_stb !== 1'b1 && t < 50) begin
      @(posedge CLK); #1; t++;
    end
    checks++;
    if (wb_stb !== 1'b1) begin
      errors++;
      $display("FAIL midrst_open got stb=%b exp 1", wb_stb);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({wb_stb, wb_cyc, sof_err} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_drop got stb=%b cyc=%b sof_err=%b exp 000", wb_stb, wb_cyc, sof_err);
    end
    RST = 1'b0; ack_en = 1'b1; zero_wait = 1'b1;
    m_idx = 0; m_sof_err = 1'b0;
    exp_q.delete(); obs_q.delete();
    repeat (3) begin
      @(posedge CLK); #1;
      if (wb_stb !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_flush got %0d stb cycles ready=%b exp 0/1", hi, pix_ready);
    end
    for (int i = 0; i < 8; i++) send_pix(16'($urandom), i == 0, 1'b1);
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_waitstate();
    test_wrap();
    test_short();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
